// File: rtl/lb_conv_row_pkg.sv
// Shared constants and FSM encoding for the line-buffer row convolver.
`ifndef filterSize
`define filterSize 5
`endif
`ifndef sizeLB
`define sizeLB 28
`endif

package lb_conv_row_pkg;
  localparam int FS_D    = `filterSize;
  localparam int LB_D    = `sizeLB;
  localparam int ACC_W_D = 24;
  localparam int PIX_W   = 8;
  localparam int WGT_W   = 8;
  localparam int PROD_W  = PIX_W + WGT_W + 1;
  localparam int ADDR_W  = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_MAC, S_OUT, S_DONE
  } state_e;
endpackage

// File: rtl/lb_conv_row_if.sv
// LB read port plus result stream; master is the convolver side.
interface lb_conv_row_if #(
  parameter int FILTER_SIZE = lb_conv_row_pkg::FS_D,
  parameter int ACC_W       = lb_conv_row_pkg::ACC_W_D
);
  logic                                lb_rd_en;
  logic [lb_conv_row_pkg::ADDR_W-1:0]  lb_rd_addr;
  logic [FILTER_SIZE*8-1:0]            lb_rd_data;
  logic                                lb_data_valid;
  logic signed [ACC_W-1:0]             out_data;
  logic                                out_valid;
  logic                                out_ready;

  modport master (
    output lb_rd_en, lb_rd_addr, out_data, out_valid,
    input  lb_rd_data, lb_data_valid, out_ready
  );
  modport slave (
    input  lb_rd_en, lb_rd_addr, out_data, out_valid,
    output lb_rd_data, lb_data_valid, out_ready
  );
endinterface

// File: rtl/lb_conv_row_dot_u8s8.sv
// Combinational unsigned-pixel x signed-weight dot product plus bias.
module dot_u8s8 import lb_conv_row_pkg::*; #(
  parameter int TAPS  = FS_D,
  parameter int ACC_W = ACC_W_D
) (
  input  logic [TAPS-1:0][PIX_W-1:0] pix_i,
  input  logic [TAPS-1:0][WGT_W-1:0] wgt_i,
  input  logic signed [ACC_W-1:0]    bias_i,
  output logic signed [ACC_W-1:0]    acc_o
);
  logic signed [PROD_W-1:0] prod [TAPS];

  // zero-extend pixel so the multiply stays signed
  for (genvar r = 0; r < TAPS; r++) begin : g_tap
    assign prod[r] = $signed({1'b0, pix_i[r]}) * $signed(wgt_i[r]);
  end

  always_comb begin
    acc_o = bias_i;
    for (int r = 0; r < TAPS; r++) acc_o = acc_o + ACC_W'(prod[r]);
  end
endmodule

// File: rtl/lb_conv_row.sv
// Walks a FILTER_SIZE-tap window across a full LB row, one read + MAC per position.
module lb_conv_row import lb_conv_row_pkg::*; #(
  parameter int FILTER_SIZE = FS_D,
  parameter int LB_SIZE     = LB_D,
  parameter int STRIDE      = 1,
  parameter int ACC_W       = ACC_W_D,
  parameter bit RELU        = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_en,
  input  logic [FILTER_SIZE*8-1:0] weights,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     lb_full,
  output logic                     busy,
  output logic                     done,
  lb_conv_row_if.master            bus
);
  localparam int LAST_ADDR = LB_SIZE - FILTER_SIZE;

  state_e                            state_q, state_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [FILTER_SIZE-1:0][WGT_W-1:0] wgt_q, wgt_d;
  logic [FILTER_SIZE-1:0][PIX_W-1:0] pix_q, pix_d;
  logic signed [ACC_W-1:0]           bias_q, bias_d, out_q, out_d, acc;

  dot_u8s8 #(.TAPS(FILTER_SIZE), .ACC_W(ACC_W)) u_dot (
    .pix_i  (pix_q),
    .wgt_i  (wgt_q),
    .bias_i (bias_q),
    .acc_o  (acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wgt_q   <= '0;
      bias_q  <= '0;
      pix_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wgt_q   <= wgt_d;
      bias_q  <= bias_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wgt_d   = wgt_q;
    bias_d  = bias_q;
    pix_d   = pix_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: if (start_en && lb_full) begin
        wgt_d   = weights;
        bias_d  = bias;
        addr_d  = '0;
        state_d = S_REQ;
      end
      S_REQ:  state_d = S_WAIT;
      // data_valid only matters here; elsewhere it is the LB write-complete pulse
      S_WAIT: if (bus.lb_data_valid) begin
        pix_d   = bus.lb_rd_data;
        state_d = S_MAC;
      end
      S_MAC: begin
        out_d   = (RELU && acc < 0) ? '0 : acc;
        state_d = S_OUT;
      end
      S_OUT: if (bus.out_ready) begin
        if (int'(addr_q) + STRIDE <= LAST_ADDR) begin
          addr_d  = addr_q + ADDR_W'(STRIDE);
          state_d = S_REQ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.lb_rd_en   = (state_q == S_REQ);
  assign bus.lb_rd_addr = addr_q;
  assign bus.out_data   = out_q;
  assign bus.out_valid  = (state_q == S_OUT);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
endmodule

// File: tb/tb_lb_conv_row.sv
// Bench: two convolvers (RELU off/on) in lockstep against an LB model and an arithmetic reference.
module tb_lb_conv_row;
  import lb_conv_row_pkg::*;
  localparam int FS   = FS_D;
  localparam int LBS  = LB_D;
  localparam int STR  = 1;
  localparam int AW   = ACC_W_D;
  localparam int WB   = FS * 8;
  localparam int NWIN = (LBS - FS) / STR + 1;

  logic clk = 1'b0, rst = 1'b0, start_en = 1'b0, lb_full = 1'b0;
  logic out_ready = 1'b0, inj_vld = 1'b0;
  logic [WB-1:0] weights = '0;
  logic signed [AW-1:0] bias = '0;
  logic busy_a, done_a, busy_b, done_b;

  lb_conv_row_if #(.FILTER_SIZE(FS), .ACC_W(AW)) ba ();
  lb_conv_row_if #(.FILTER_SIZE(FS), .ACC_W(AW)) bb ();

  lb_conv_row #(.FILTER_SIZE(FS), .LB_SIZE(LBS), .STRIDE(STR), .ACC_W(AW), .RELU(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start_en(start_en), .weights(weights), .bias(bias),
    .lb_full(lb_full), .busy(busy_a), .done(done_a), .bus(ba));
  lb_conv_row #(.FILTER_SIZE(FS), .LB_SIZE(LBS), .STRIDE(STR), .ACC_W(AW), .RELU(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start_en(start_en), .weights(weights), .bias(bias),
    .lb_full(lb_full), .busy(busy_b), .done(done_b), .bus(bb));

  always #5 clk = ~clk;

  // reference row contents and the coefficients the current run was started with
  int row [LBS];
  int w [FS];
  int b;

  // LB model: address sampled the cycle after the request, data valid the cycle after that
  bit req_a, req_b, vld_a, vld_b;
  int la_a, la_b;
  always @(posedge clk) begin
    req_a <= ba.lb_rd_en;
    req_b <= bb.lb_rd_en;
    vld_a <= req_a;
    vld_b <= req_b;
    if (req_a) la_a <= int'(ba.lb_rd_addr);
    if (req_b) la_b <= int'(bb.lb_rd_addr);
  end
  assign ba.lb_data_valid = vld_a | inj_vld;
  assign bb.lb_data_valid = vld_b | inj_vld;
  assign ba.out_ready     = out_ready;
  assign bb.out_ready     = out_ready;
  always_comb begin
    ba.lb_rd_data = '0;
    bb.lb_rd_data = '0;
    for (int r = 0; r < FS; r++) begin
      if (la_a + r < LBS) ba.lb_rd_data[r*8 +: 8] = 8'(row[la_a + r]);
      if (la_b + r < LBS) bb.lb_rd_data[r*8 +: 8] = 8'(row[la_b + r]);
    end
  end

  int addr_log [$];
  int n_done = 0, n_bad = 0;
  always @(negedge clk) begin
    if (ba.lb_rd_en) addr_log.push_back(int'(ba.lb_rd_addr));
    if (done_a) n_done++;
    if (ba.lb_rd_en && ba.out_valid) n_bad++;
    if (busy_a != busy_b || ba.out_valid != bb.out_valid || done_a != done_b) n_bad++;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(int k);
    longint s = longint'(b);
    for (int r = 0; r < FS; r++) s += longint'(row[k*STR + r]) * longint'(w[r]);
    return s;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < LBS; i++) row[i] = int'($urandom_range(0, 255));
    for (int r = 0; r < FS; r++) w[r] = int'($urandom_range(0, 255)) - 128;
    b = int'($urandom_range(0, 200000)) - 100000;
  endtask

  task automatic do_run(input int bp_win, input int bp_cyc, input bit rnd,
                        input int inj_win, input int abort_win);
    int k, cyc, lat, hold, a0, d0, bad0, bad_addr;
    longint e;
    for (int r = 0; r < FS; r++) weights[r*8 +: 8] = 8'(w[r]);
    bias = AW'(b);
    a0 = addr_log.size(); d0 = n_done; bad0 = n_bad;
    lb_full = 1'b1; start_en = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!busy_a && cyc < 8);
    chk("start_busy", busy_a, 1);
    lb_full = 1'b0; start_en = 1'b0;
    // coefficients seen after start must not matter
    weights = WB'({$urandom(), $urandom()});
    bias    = AW'($urandom());
    k = 0;
    while (k < NWIN) begin
      lat = ba.lb_rd_en ? 0 : -1;
      cyc = 0;
      while (!ba.out_valid && cyc < 64) begin
        @(negedge clk); cyc++;
        if (ba.lb_rd_en) lat = 0; else if (lat >= 0) lat++;
        if (k == abort_win && lat == 1) begin
          chk("abort_in_wait", {busy_a, ba.lb_rd_en, ba.out_valid}, 3'b100);
          rst = 1'b0; #1;
          chk("abort_busy", busy_a, 0);
          chk("abort_rd_en", ba.lb_rd_en, 0);
          chk("abort_addr", ba.lb_rd_addr, 0);
          chk("abort_valid", ba.out_valid, 0);
          chk("abort_data", ba.out_data, 0);
          chk("abort_done", done_a, 0);
          @(negedge clk); rst = 1'b1;
          return;
        end
      end
      if (!ba.out_valid) begin chk("valid_timeout", 0, 1); return; end
      chk("latency", lat, 4);
      e = model(k);
      chk("out_a", ba.out_data, e);
      chk("out_b", bb.out_data, (e < 0) ? 0 : e);
      if (k == bp_win)       hold = bp_cyc;
      else if (k == inj_win) hold = 2;
      else if (out_ready)    hold = 0;
      else                   hold = rnd ? int'($urandom_range(0, 3)) : 0;
      if (hold > 0) out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        if (k == inj_win && h == 0) begin
          inj_vld = 1'b1; lb_full = 1'b1; start_en = 1'b1;
        end
        @(negedge clk);
        inj_vld = 1'b0; lb_full = 1'b0; start_en = 1'b0;
        chk("hold_valid", ba.out_valid, 1);
        chk("hold_data", ba.out_data, e);
        chk("hold_no_rd", ba.lb_rd_en, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      k++;
    end
    cyc = 0;
    while (busy_a && cyc < 8) begin @(negedge clk); cyc++; end
    chk("end_idle", busy_a, 0);
    repeat (3) @(negedge clk);
    chk("no_restart", busy_a, 0);
    chk("done_pulses", n_done - d0, 1);
    chk("rd_count", addr_log.size() - a0, NWIN);
    bad_addr = 0;
    for (int i = 0; i < NWIN && a0 + i < addr_log.size(); i++)
      if (addr_log[a0 + i] != i * STR) bad_addr++;
    chk("addr_seq", bad_addr, 0);
    chk("protocol", n_bad - bad0, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_rd_en", ba.lb_rd_en, 0);
    chk("rst_addr", ba.lb_rd_addr, 0);
    chk("rst_valid", ba.out_valid, 0);
    chk("rst_data", ba.out_data, 0);
    chk("rst_done", done_a, 0);
    rst = 1'b1;

    // write-complete pulse while idle and LB not full
    @(negedge clk); start_en = 1'b1; inj_vld = 1'b1;
    @(negedge clk); inj_vld = 1'b0; start_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_vld_busy", busy_a, 0);
    chk("idle_vld_out", ba.out_valid, 0);

    for (int i = 0; i < LBS; i++) row[i] = 1;
    for (int r = 0; r < FS; r++) w[r] = 1;
    b = 0;
    do_run(-1, 0, 1'b0, -1, -1);

    for (int i = 0; i < LBS; i++) row[i] = 255;
    for (int r = 0; r < FS; r++) w[r] = -128;
    b = 0;
    do_run(-1, 0, 1'b0, -1, -1);

    for (int i = 0; i < LBS; i++) row[i] = i;
    for (int r = 0; r < FS; r++) w[r] = 0;
    w[0] = 1; w[FS-1] = -1;
    b = 10;
    do_run(-1, 0, 1'b0, -1, -1);

    fill_rand();
    do_run(3, 7, 1'b0, 6, -1);

    fill_rand();
    do_run(-1, 0, 1'b0, -1, 10);
    fill_rand();
    do_run(-1, 0, 1'b0, -1, -1);

    for (int n = 0; n < 3; n++) begin
      fill_rand();
      do_run(-1, 0, 1'b1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
